// File: rtl/csr_rf_arbiter.sv
// Two-port arbiter for a single-port CSR register file (port A: APB host, port B: status updater).
// Define CSR_ARB_FIXED_PRIO_EN for fixed A-over-B priority; otherwise ties alternate round-robin.
module csr_rf_arbiter #(
  parameter int unsigned AW       = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_reqA,
  input  logic          i_reqB,
  input  logic          i_weA,
  input  logic          i_weB,
  input  logic [AW-1:0] i_addrA,
  input  logic [AW-1:0] i_addrB,
  input  logic [DW-1:0] i_wdataA,
  input  logic [DW-1:0] i_wdataB,
  output logic          o_ackA,
  output logic          o_ackB,
  output logic          o_errA,
  output logic          o_errB,
  output logic [DW-1:0] o_rdataA,
  output logic [DW-1:0] o_rdataB,
  output logic          o_rf_wr_en,
  output logic          o_rf_rd_en,
  output logic [AW-1:0] o_rf_addr,
  output logic [DW-1:0] o_rf_wdata,
  input  logic [DW-1:0] i_rf_rdata,
  output logic          o_busy
);

  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            gnt_b_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   cnt_q;
  logic            err_a_q, err_b_q;
  logic [DW-1:0]   rdata_a_q, rdata_b_q;
  logic            pick_b;
  logic            legal;

`ifdef CSR_ARB_FIXED_PRIO_EN
  assign pick_b = ~i_reqA;
`else
  logic last_b_q;

  // Tie goes to whichever port was not served last.
  assign pick_b = i_reqB & (~i_reqA | ~last_b_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_b_q <= 1'b1;
    end else if (state_q == StResp) begin
      last_b_q <= gnt_b_q;
    end
  end
`endif

  assign legal = 32'(addr_q) < NUM_REGS;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_reqA || i_reqB) state_d = StIssue;
      StIssue: state_d = (legal && !we_q) ? StWait : StResp;
      StWait:  if (cnt_q == '0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_a_q   <= 1'b0;
      err_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (i_reqA || i_reqB) begin
            gnt_b_q <= pick_b;
            we_q    <= pick_b ? i_weB    : i_weA;
            addr_q  <= pick_b ? i_addrB  : i_addrA;
            wdata_q <= pick_b ? i_wdataB : i_wdataA;
          end
        end
        StIssue: begin
          cnt_q <= CW'(RD_LAT - 1);
          if (!legal) begin
            if (gnt_b_q) begin
              err_b_q   <= 1'b1;
              rdata_b_q <= '0;
            end else begin
              err_a_q   <= 1'b1;
              rdata_a_q <= '0;
            end
          end else if (we_q) begin
            // Writes clear the error flag but keep the last read data.
            if (gnt_b_q) err_b_q <= 1'b0;
            else         err_a_q <= 1'b0;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (gnt_b_q) begin
              err_b_q   <= 1'b0;
              rdata_b_q <= i_rf_rdata;
            end else begin
              err_a_q   <= 1'b0;
              rdata_a_q <= i_rf_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy     = (state_q != StIdle);
    o_rf_wr_en = (state_q == StIssue) && legal && we_q;
    o_rf_rd_en = (state_q == StIssue) && legal && !we_q;
    o_rf_addr  = (state_q == StIssue) ? addr_q  : '0;
    o_rf_wdata = (state_q == StIssue) ? wdata_q : '0;
    o_ackA     = (state_q == StResp) && !gnt_b_q;
    o_ackB     = (state_q == StResp) && gnt_b_q;
    o_errA     = err_a_q;
    o_errB     = err_b_q;
    o_rdataA   = rdata_a_q;
    o_rdataB   = rdata_b_q;
  end

endmodule

// File: doc/csr_rf_arbiter.md
Name: csr_rf_arbiter

Overview:
- Arbitrates a single-port CSR register file between two requesters: port A (APB host side) and port B (internal hardware status updater).
- Serialises accesses, drives the register file's write/read strobes, and returns read data, error flag and a one-cycle ack to the winning requester.
- Sits between the APB slave front-end and the register file.

Parameters:
- AW, 3, address width in bits.
- DW, 8, data width in bits.
- NUM_REGS, 8, number of implemented registers; addresses >= NUM_REGS are illegal.
- RD_LAT, 1, register file read latency in cycles (legal range 1..4).

Ports:
- i_clk  input  1  clock; all logic rising-edge.
- i_rst  input  1  synchronous reset, active-high.
- i_reqA / i_reqB  input  1  access request; held until the matching ack.
- i_weA / i_weB  input  1  1 = write, 0 = read; stable while req is high.
- i_addrA / i_addrB  input  AW  register address; stable while req is high.
- i_wdataA / i_wdataB  input  DW  write data; stable while req is high.
- o_ackA / o_ackB  output  1  one-cycle completion pulse.
- o_errA / o_errB  output  1  valid with ack; 1 = illegal address.
- o_rdataA / o_rdataB  output  DW  read data; valid with ack and held until the next ack to that port.
- o_rf_wr_en  output  1  register file write strobe.
- o_rf_rd_en  output  1  register file read strobe.
- o_rf_addr  output  AW  register file address.
- o_rf_wdata  output  DW  register file write data.
- i_rf_rdata  input  DW  register file read data.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - All outputs go to 0 and the FSM goes to IDLE; last_grant = B.
  - An in-flight access is dropped with no ack.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port that is not last_grant (round-robin). The first tie after reset goes to A.
  - On grant, latch we/addr/wdata and the grant id internally, then go to ISSUE.
- ISSUE (cycle T):
  - Legal address: assert exactly one of o_rf_wr_en / o_rf_rd_en for this single cycle, with o_rf_addr and o_rf_wdata from the latched values. Writes go to RESP; reads go to WAIT.
  - Illegal address: assert no strobe, set err, rdata = 0, go to RESP.
- WAIT:
  - A counter starts at RD_LAT-1 and counts down.
  - When it reaches 0, i_rf_rdata is sampled (cycle T+RD_LAT), then go to RESP.
- RESP: pulse the granted port's ack for one cycle with err/rdata valid. Update last_grant, go to IDLE.
- Latency from strobe cycle T:
  - Write ack at T+1.
  - Read ack at T+RD_LAT+1.
  - Requests are sampled in IDLE only, so throughput is one access per 3 cycles (write) or RD_LAT+3 cycles (read).
- o_rf_addr and o_rf_wdata return to 0 outside ISSUE. Strobes are never asserted together.
- Requester rule: drop req at the clock edge ending the ack cycle. A req still high in IDLE after that is treated as a new request.
- o_errX and o_rdataX hold their values until the next ack to the same port. Writes leave o_rdataX unchanged.
- A request arriving while busy waits in IDLE arbitration; there is no queueing beyond the held req.

Optional Feature:
- Macro: CSR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; A always wins a tie and last_grant is ignored.
- Undefined: round-robin as above.

Test Plan:
- Reset for 2 cycles, then A writes addr 2 = 8'h64 -> o_rf_wr_en high 1 cycle with addr 2 / data 8'h64; o_ackA one cycle later; o_errA = 0.
- A reads addr 2; RD_LAT = 1; register file returns 8'h64 one cycle after rd_en -> o_ackA at T+2, o_rdataA = 8'h64; no activity on port B.
- reqA and reqB rise in the same cycle after reset, repeated 4 times -> grant order A, B, A, B. With CSR_ARB_FIXED_PRIO_EN -> A, A, A, A while A re-requests.
- NUM_REGS = 6; B reads addr 7 -> no rf strobe; o_ackB with o_errB = 1 and o_rdataB = 0.
- RD_LAT = 3; B reads addr 1 = 8'h5A -> o_ackB exactly 4 cycles after rd_en; o_busy high from ISSUE through RESP.
- i_rst asserted during WAIT of a read -> next cycle all outputs 0 and FSM in IDLE; no ack ever issued; a following write completes normally.
